// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-addressed data-memory responder for the CPU MEM stage,
//               with programmable wait states and a pipeline stall output.
//               Optional macro DMEM_MISALIGN_ERR_EN adds mem_err reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        stall,
    output logic        busy
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        mem_err
`endif
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_ack;
    logic          r_mis;
    logic [31:0]   r_mem [DEPTH];

    logic [1:0]    w_next_state;
    logic          w_accept;
    logic          w_enter_resp;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_we_src;
    logic          w_mis;
    logic          w_mis_src;
    logic          w_unused_addr;

    assign w_idx         = mem_addr[AW+1:2];
    assign w_unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};
    assign w_accept      = (r_state == c_st_idle) && mem_req;

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_mis = (mem_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    // With zero wait states RESP is entered straight from IDLE, so the
    // read must use the live request rather than the captured copy.
    assign w_rd_idx  = (r_state == c_st_idle) ? w_idx  : r_idx;
    assign w_we_src  = (r_state == c_st_idle) ? mem_we : r_we;
    assign w_mis_src = (r_state == c_st_idle) ? w_mis  : r_mis;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (mem_req) begin
                    w_next_state = (c_wait_load != 4'd0) ? c_st_wait : c_st_resp;
                end
            end
            c_st_wait: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = c_st_resp;
                end
            end
            c_st_resp: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
        w_enter_resp = (w_next_state == c_st_resp) && (r_state != c_st_resp);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_ack   <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= w_enter_resp;
            if (w_accept) begin
                r_we    <= mem_we;
                r_idx   <= w_idx;
                r_wdata <= mem_wdata;
                r_cnt   <= c_wait_load;
                r_mis   <= w_mis;
            end else if ((r_state == c_st_wait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp && !w_we_src && !w_mis_src) begin
                r_rdata <= r_mem[w_rd_idx];
            end else begin
                r_rdata <= 32'd0;
            end
        end
    end

    // Store commits on the edge leaving RESP; an async reset clears r_state
    // first, so an interrupted store never reaches the array.
    always_ff @(posedge Clock) begin
        if ((r_state == c_st_resp) && r_we && !r_mis) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic r_err;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_resp && w_mis_src;
        end
    end

    assign mem_err = r_err;
`endif

    assign mem_rdata = r_rdata;
    assign mem_ack   = r_ack;
    assign busy      = (r_state != c_st_idle);
    assign stall     = mem_req & ~r_ack;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed, table-driven bench for dmem_responder
//               (DEPTH=256, WAIT_CYCLES=2); macro DMEM_MISALIGN_ERR_EN aware.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;
    localparam int AW          = 8;
    localparam int LAT         = WAIT_CYCLES + 1;

    logic        Clock  = 1'b0;
    logic        Resetn = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_we  = 1'b0;
    logic [31:0] mem_addr  = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        busy;
`ifdef DMEM_MISALIGN_ERR_EN
    logic        mem_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .AW          (AW)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .busy      (busy)
`ifdef DMEM_MISALIGN_ERR_EN
        ,
        .mem_err   (mem_err)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one request (from posedge+1) and follows it to its ack.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat,
                          input bit keep, input bit scramble);
        int       lat;
        bit       pre_bad;
        logic     got_err;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        lat       = 0;
        pre_bad   = 1'b0;
        got_err   = 1'b0;
        while (lat < 20) begin
            @(posedge Clock);
            #1;
            lat++;
            if (scramble && lat == 1) begin
                mem_addr  = addr ^ 32'h4;
                mem_wdata = ~wdata;
                mem_we    = ~we;
            end
            if (mem_ack) break;
            if (!stall || mem_rdata != 32'd0) pre_bad = 1'b1;
`ifdef DMEM_MISALIGN_ERR_EN
            if (mem_err) pre_bad = 1'b1;
`endif
        end
        check32({name, " ack latency"}, 32'(lat), 32'(exp_lat));
        check32({name, " pre-ack stall/rdata"}, {31'd0, pre_bad}, 32'd0);
        check32({name, " rdata@ack"}, mem_rdata, exp_rdata);
        check32({name, " stall/busy@ack"}, {30'd0, stall, busy}, 32'd1);
`ifdef DMEM_MISALIGN_ERR_EN
        got_err = mem_err;
        check32({name, " err@ack"}, {31'd0, got_err}, {31'd0, exp_err});
`else
        got_err = exp_err;
`endif
        if (!keep) begin
            mem_req = 1'b0;
            @(posedge Clock);
            #1;
            check32({name, " idle after ack"}, {mem_ack, busy, 30'd0} | mem_rdata, 32'd0);
        end
    endtask

    vec_t vecs[$];
    int   ack_seen;

    initial begin
        vecs.push_back('{"st 0x10",    1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{"ld 0x10",    1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{"st 0x404",   1'b1, 32'h0000_0404, 32'h1234_5678, 32'h0});
        vecs.push_back('{"ld 0x004",   1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678});
        vecs.push_back('{"st 0x30=0",  1'b1, 32'h0000_0030, 32'h0,         32'h0});
        vecs.push_back('{"st 0x3FC",   1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0});
        vecs.push_back('{"ld 0x3FC",   1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D});
        vecs.push_back('{"ld 0x7FC",   1'b0, 32'h0000_07FC, 32'h0,         32'hCAFE_F00D});
        vecs.push_back('{"ld 0x30",    1'b0, 32'h0000_0030, 32'hFFFF_FFFF, 32'h0});
`ifndef DMEM_MISALIGN_ERR_EN
        vecs.push_back('{"ld 0x13",    1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF});
`endif

        #12;
        check32("reset outputs", {mem_ack, busy, stall, 29'd0} | mem_rdata, 32'd0);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        foreach (vecs[i]) begin
            do_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, 1'b0, LAT, 1'b0, 1'b0);
        end

        // Back-to-back: request held high through the store ack into a load.
        do_req("b2b st 0x20", 1'b1, 32'h20, 32'h1, 32'h0, 1'b0, LAT, 1'b1, 1'b0);
        do_req("b2b ld 0x20", 1'b0, 32'h20, 32'h0, 32'h1, 1'b0, LAT + 1, 1'b0, 1'b0);

        // Inputs changed mid-flight must not disturb the captured request.
        do_req("scrambled st 0x40", 1'b1, 32'h40, 32'h1111_1111, 32'h0, 1'b0, LAT, 1'b0, 1'b1);
        do_req("ld 0x40", 1'b0, 32'h40, 32'h0, 32'h1111_1111, 1'b0, LAT, 1'b0, 1'b0);

        // Reset asserted during WAIT of a store: no ack, array untouched.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h30;
        mem_wdata = 32'hAAAA_5555;
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        check32("mid-op busy before reset", {31'd0, busy}, 32'd1);
        Resetn = 1'b0;
        #1;
        check32("mid-op reset outputs", {mem_ack, busy, 30'd0} | mem_rdata, 32'd0);
        mem_req = 1'b0;
        ack_seen = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge Clock);
            #1;
            if (mem_ack) ack_seen++;
        end
        Resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clock);
            #1;
            if (mem_ack) ack_seen++;
        end
        check32("no ack after reset", 32'(ack_seen), 32'd0);
        do_req("ld 0x30 after reset", 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, LAT, 1'b0, 1'b0);

`ifdef DMEM_MISALIGN_ERR_EN
        do_req("misaligned st 0x31", 1'b1, 32'h31, 32'hFFFF_FFFF, 32'h0, 1'b1, LAT, 1'b0, 1'b0);
        do_req("ld 0x30 unchanged", 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, LAT, 1'b0, 1'b0);
        do_req("misaligned ld 0x12", 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, LAT, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
